titan_cmd_issuer: RTL
=====================

# titan_cmd_issuer

Host-side command issuer for the Titan SPI instruction protocol. It accepts one command (opcode, address, value) per handshake and serializes it into the opcode-specific byte frame for an SPI master byte interface. For READ-back style opcodes it captures the bytes returned on MISO into a 32-bit response. It is the initiator counterpart of the device-side instruction decoder and sits between the test/host controller and the SPI master.

## Interface
- GAP_CYCLES, 4: idle cycles enforced after the last byte of a frame, so the device can re-arm its instruction decode.
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_instr_i  in  8  opcode: WRITE=1, READ=2, STREAM=3, BIND_INTERRUPT=4, BIND_READ_ADDRESS=5, BIND_WRITE_ADDRESS=6, TRANSFER=7, REPEAT=8.
- cmd_addr_i  in  24  address.
- cmd_value_i  in  32  write/stream value.
- spi_tx_valid_o  out  1  byte offered to SPI master.
- spi_tx_byte_o  out  8  byte to shift out on MOSI.
- spi_tx_ready_i  in  1  master accepts the byte this cycle.
- spi_rx_valid_i  in  1  one-cycle pulse: the exchange for the last accepted byte has completed.
- spi_rx_byte_i  in  8  MISO byte from that exchange.
- rsp_valid_o  out  1  one-cycle pulse with response.
- rsp_data_o  out  32  response data; holds its value until the next response.
- err_o  out  1  one-cycle pulse on an illegal opcode.

## Operation
- Frames are sent MSB-first within every field:
  - WRITE: instr, addr[23:16], addr[15:8], addr[7:0], value[31:24] … value[7:0]. 8 bytes.
  - READ and BIND_*: instr, addr[23:16], addr[15:8], addr[7:0]. 4 bytes.
  - STREAM: instr, value[31:24] … value[7:0]. 5 bytes.
  - TRANSFER: instr, then pad 0x00. 2 bytes.
  - REPEAT: instr. 1 byte.
- Response capture: rx bytes are indexed by frame position; position 0 is always discarded.
  - STREAM: positions 1..4 are shifted into rsp_data_o MSB-first.
  - TRANSFER: position 1 goes to rsp_data_o[7:0], with upper bits 0.
  - rsp_valid_o pulses only for STREAM and TRANSFER.
- Illegal opcode (0 or >8) accepted in IDLE:
  - err_o pulses the next cycle.
  - No bytes are sent, and the block stays in IDLE.
- Command fields are registered at acceptance; later input changes have no effect.
- FSM:
  - IDLE → LOAD on cmd_valid_i & legal opcode.
  - LOAD → SEND. The frame is built into a 64-bit shift register plus a byte count.
  - SEND → WAIT_RX on spi_tx_ready_i.
  - WAIT_RX → SEND on spi_rx_valid_i when bytes remain, otherwise → GAP.
  - GAP → IDLE after GAP_CYCLES cycles. rsp_valid_o pulses on GAP entry.
- Exactly one byte is outstanding at a time; the next byte is never offered before the rx pulse for the previous one.
- spi_rx_valid_i outside WAIT_RX is ignored.

## Timing
- Reset values: cmd_ready_o=0 during reset and 1 the first cycle after; all other outputs, including spi_tx_byte_o and rsp_data_o, are 0. State is IDLE.
- Reset asserted mid-frame abandons the frame immediately; the remaining bytes are never sent.
- Acceptance at cycle N:
  - cmd_ready_o=0 from N+1.
  - spi_tx_valid_o=1 with byte 0 at N+2.
- Handshake on spi_tx_valid_o:
  - It stays high, with spi_tx_byte_o stable, until the cycle spi_tx_ready_i=1.
  - It drops the following cycle.
- spi_rx_valid_i at cycle M with bytes remaining: next byte valid at M+1.
- spi_rx_valid_i at cycle M on the last byte:
  - rsp_valid_o at M+1.
  - cmd_ready_o at M+1+GAP_CYCLES.
- spi_tx_ready_i and spi_rx_valid_i high in the same cycle in SEND: the ready is taken, and the rx pulse is not counted.
- Counters: byte index is 4 bits; gap counter is $clog2(GAP_CYCLES+1) bits; GAP_CYCLES=0 is legal.

## Structure
- Package titan_comms_pkg holds:
  - opcode constants;
  - frame length function (opcode → 1..8, 0 = illegal);
  - state enum.
- The device-side decoder imports the same package.
- No sub-module. The frame builder is a package function feeding the shift register.

## Test plan
- WRITE addr=0x123456 value=0xDEADBEEF with immediate ready and rx → bytes 01 12 34 56 DE AD BE EF; no rsp_valid_o; cmd_ready_o returns GAP_CYCLES+1 cycles after the last rx pulse.
- STREAM value=0 with MISO bytes xx,A1,B2,C3,D4 → bytes 03 00 00 00 00; rsp_data_o=0xA1B2C3D4 and one rsp_valid_o pulse.
- TRANSFER with MISO xx,5A → bytes 07 00; rsp_data_o=0x0000005A.
- spi_tx_ready_i held low 10 cycles during READ addr=0x00ABCD → byte 0x00 held stable; frame 02 00 AB CD; back-to-back REPEAT emits single 08.
- Opcode 0x09 → err_o pulse, no spi_tx_valid_o, cmd_ready_o stays 1.
- rst_i asserted after byte 3 of WRITE → all outputs 0 in the same cycle; a new READ issued after reset emits a clean 4-byte frame.

Source files
------------

// File: rtl/titan_comms_pkg.sv
// Shared Titan SPI instruction protocol definitions: opcodes, command payload,
// frame length/builder helpers and the issuer state encoding.
package titan_comms_pkg;

  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned VALUE_W    = 32;
  localparam int unsigned FRAME_W    = 64;
  localparam int unsigned BYTE_IDX_W = 4;

  localparam logic [INSTR_W-1:0] OP_WRITE              = 8'd1;
  localparam logic [INSTR_W-1:0] OP_READ               = 8'd2;
  localparam logic [INSTR_W-1:0] OP_STREAM             = 8'd3;
  localparam logic [INSTR_W-1:0] OP_BIND_INTERRUPT     = 8'd4;
  localparam logic [INSTR_W-1:0] OP_BIND_READ_ADDRESS  = 8'd5;
  localparam logic [INSTR_W-1:0] OP_BIND_WRITE_ADDRESS = 8'd6;
  localparam logic [INSTR_W-1:0] OP_TRANSFER           = 8'd7;
  localparam logic [INSTR_W-1:0] OP_REPEAT             = 8'd8;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
    logic [VALUE_W-1:0] value;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RX,
    ST_GAP
  } state_e;

  // Number of bytes on the wire for an opcode; 0 marks an illegal opcode.
  function automatic logic [BYTE_IDX_W-1:0] frame_len(input logic [INSTR_W-1:0] instr);
    case (instr)
      OP_WRITE:              frame_len = 4'd8;
      OP_READ,
      OP_BIND_INTERRUPT,
      OP_BIND_READ_ADDRESS,
      OP_BIND_WRITE_ADDRESS: frame_len = 4'd4;
      OP_STREAM:             frame_len = 4'd5;
      OP_TRANSFER:           frame_len = 4'd2;
      OP_REPEAT:             frame_len = 4'd1;
      default:               frame_len = 4'd0;
    endcase
  endfunction

  // Frame left-justified so byte 0 sits in the top byte of the shift register.
  function automatic logic [FRAME_W-1:0] build_frame(input cmd_t cmd);
    case (cmd.instr)
      OP_WRITE:              build_frame = {cmd.instr, cmd.addr, cmd.value};
      OP_READ,
      OP_BIND_INTERRUPT,
      OP_BIND_READ_ADDRESS,
      OP_BIND_WRITE_ADDRESS: build_frame = {cmd.instr, cmd.addr, 32'h0};
      OP_STREAM:             build_frame = {cmd.instr, cmd.value, 24'h0};
      default:               build_frame = {cmd.instr, 56'h0};
    endcase
  endfunction

  function automatic logic has_response(input logic [INSTR_W-1:0] instr);
    has_response = (instr == OP_STREAM) || (instr == OP_TRANSFER);
  endfunction

endpackage

// File: rtl/titan_cmd_issuer.sv
// Host-side Titan command issuer: serializes one command into its SPI byte
// frame, one byte outstanding at a time, and captures MISO responses.
module titan_cmd_issuer
  import titan_comms_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [INSTR_W-1:0] cmd_instr_i,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic [VALUE_W-1:0] cmd_value_i,
  output logic               spi_tx_valid_o,
  output logic [7:0]         spi_tx_byte_o,
  input  logic               spi_tx_ready_i,
  input  logic               spi_rx_valid_i,
  input  logic [7:0]         spi_rx_byte_i,
  output logic               rsp_valid_o,
  output logic [31:0]        rsp_data_o,
  output logic               err_o
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [BYTE_IDX_W-1:0]  len_q, len_d;
  logic [BYTE_IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [31:0]            cap_q, cap_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      frame_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      cap_q       <= '0;
      cmd_ready_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      cap_q       <= cap_d;
      cmd_ready_q <= cmd_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    frame_d     = frame_q;
    len_d       = len_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    cap_d       = cap_q;
    cmd_ready_d = cmd_ready_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          if (frame_len(cmd_instr_i) != '0) begin
            cmd_d       = '{instr: cmd_instr_i, addr: cmd_addr_i, value: cmd_value_i};
            cmd_ready_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        frame_d    = build_frame(cmd_q);
        len_d      = frame_len(cmd_q.instr);
        idx_d      = '0;
        cap_d      = '0;
        tx_valid_d = 1'b1;
        tx_byte_d  = cmd_q.instr;
        state_d    = ST_SEND;
      end

      // An rx pulse coinciding with the ready is deliberately not observed here.
      ST_SEND: begin
        if (spi_tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT_RX;
        end
      end

      ST_WAIT_RX: begin
        if (spi_rx_valid_i) begin
          if ((idx_q != '0) && has_response(cmd_q.instr)) begin
            cap_d = {cap_q[23:0], spi_rx_byte_i};
          end
          if ((idx_q + 4'd1) < len_q) begin
            idx_d      = idx_q + 4'd1;
            frame_d    = {frame_q[FRAME_W-9:0], 8'h00};
            tx_byte_d  = frame_q[FRAME_W-9 -: 8];
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
          end else begin
            gap_d = '0;
            if (has_response(cmd_q.instr)) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = cap_d;
            end
            if (GAP_CYCLES == 0) begin
              cmd_ready_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign spi_tx_valid_o = tx_valid_q;
  assign spi_tx_byte_o  = tx_byte_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign err_o          = err_q;

endmodule
